// File: rtl/cp0_exc_ctrl_pkg.sv
// cp0_exc_ctrl_pkg: shared constants and field-packing helpers for the
// coprocessor-0 exception controller.
//   - CP0 register numbers (SR, Cause, EPC, PRId)
//   - ExcCode values understood by the handler
//   - Bit positions of the SR and Cause fields
//   - pack_sr / pack_cause build the architectural read views; every bit
//     that is not a defined field reads as zero
package cp0_exc_ctrl_pkg;

    localparam logic [4:0] CP0_SR    = 5'd12;
    localparam logic [4:0] CP0_CAUSE = 5'd13;
    localparam logic [4:0] CP0_EPC   = 5'd14;
    localparam logic [4:0] CP0_PRID  = 5'd15;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam int IM_HI   = 15;
    localparam int IM_LO   = 10;
    localparam int IP_HI   = 15;
    localparam int IP_LO   = 10;
    localparam int EXL_BIT = 1;
    localparam int IE_BIT  = 0;
    localparam int BD_BIT  = 31;
    localparam int EXC_HI  = 6;
    localparam int EXC_LO  = 2;

    function automatic logic [31:0] pack_sr(input logic [5:0] im,
                                            input logic       exl,
                                            input logic       ie);
        logic [31:0] v;
        v                = 32'h0000_0000;
        v[IM_HI:IM_LO]   = im;
        v[EXL_BIT]       = exl;
        v[IE_BIT]        = ie;
        return v;
    endfunction

    function automatic logic [31:0] pack_cause(input logic       bd,
                                               input logic [5:0] ip,
                                               input logic [4:0] code);
        logic [31:0] v;
        v                = 32'h0000_0000;
        v[BD_BIT]        = bd;
        v[IP_HI:IP_LO]   = ip;
        v[EXC_HI:EXC_LO] = code;
        return v;
    endfunction

endpackage

// File: rtl/cp0_exc_ctrl.sv
// cp0_exc_ctrl: coprocessor-0 exception/interrupt controller.
// Merges the M-stage exception code with level-sensitive hardware
// interrupts, decides whether to take an exception, and holds SR, Cause,
// EPC and PRId for mtc0/mfc0/eret.
// Ports:
//   clk, reset        clock; asynchronous active-high reset
//   pc, bd_in         M-stage PC and branch-delay-slot flag
//   exc_code_in       M-stage exception code (0 = none)
//   hw_int            external interrupt lines (level)
//   cp0_addr/we/wdata mtc0 / mfc0 access
//   eret_in           eret in the M stage
//   cp0_rdata         mfc0 read data (combinational, pre-edge value)
//   req               take exception this cycle, flush pipeline (combinational)
//   epc_out           EPC register
//   handler_pc        constant exception entry address
module cp0_exc_ctrl
    import cp0_exc_ctrl_pkg::*;
#(
    parameter logic [31:0] PRID_VAL   = 32'h0000_2021,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic        bd_in,
    input  logic [4:0]  exc_code_in,
    input  logic [5:0]  hw_int,
    input  logic [4:0]  cp0_addr,
    input  logic        cp0_we,
    input  logic [31:0] cp0_wdata,
    input  logic        eret_in,
    output logic [31:0] cp0_rdata,
    output logic        req,
    output logic [31:0] epc_out,
    output logic [31:0] handler_pc
);

    logic [5:0]  im_r;
    logic        exl_r;
    logic        ie_r;
    logic        bd_r;
    logic [5:0]  ip_r;
    logic [4:0]  exc_code_r;
    logic [31:0] epc_r;

    logic        int_req_s;
    logic        exc_req_s;
    logic        req_s;

    // Interrupts look at the live lines, not the latched IP, so a raised line
    // is taken in the same cycle it appears.
    assign int_req_s = (|(hw_int & im_r)) & ie_r & ~exl_r;
    assign exc_req_s = (exc_code_in != 5'd0) & ~exl_r;
    assign req_s     = int_req_s | exc_req_s;

    assign req        = req_s;
    assign epc_out    = epc_r;
    assign handler_pc = HANDLER_PC;

    // CP0 state update: exception entry, eret, and mtc0 (in that priority).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            im_r       <= 6'd0;
            exl_r      <= 1'b0;
            ie_r       <= 1'b0;
            bd_r       <= 1'b0;
            ip_r       <= 6'd0;
            exc_code_r <= 5'd0;
            epc_r      <= 32'h0000_0000;
        end else begin
            ip_r <= hw_int;
            if (req_s) begin
                // The flushed instruction's mtc0/eret is dropped here.
                exl_r      <= 1'b1;
                exc_code_r <= int_req_s ? EXC_INT : exc_code_in;
                bd_r       <= bd_in;
                // pc[1:0] survive the subtraction, so a misaligned PC is kept.
                epc_r      <= bd_in ? (pc - 32'd4) : pc;
            end else if (eret_in) begin
                exl_r <= 1'b0;
            end else if (cp0_we) begin
                case (cp0_addr)
                    CP0_SR: begin
                        im_r  <= cp0_wdata[IM_HI:IM_LO];
                        exl_r <= cp0_wdata[EXL_BIT];
                        ie_r  <= cp0_wdata[IE_BIT];
                    end
                    CP0_EPC: begin
                        epc_r <= cp0_wdata;
                    end
                    default: begin
                        // Cause, PRId and unmapped numbers are not writable.
                    end
                endcase
            end else begin
                // No event: hold state.
            end
        end
    end

    // mfc0 read mux; no write-through, the pipeline forwards.
    always_comb begin
        cp0_rdata = 32'h0000_0000;
        case (cp0_addr)
            CP0_SR:    cp0_rdata = pack_sr(im_r, exl_r, ie_r);
            CP0_CAUSE: cp0_rdata = pack_cause(bd_r, ip_r, exc_code_r);
            CP0_EPC:   cp0_rdata = epc_r;
            CP0_PRID:  cp0_rdata = PRID_VAL;
            default:   cp0_rdata = 32'h0000_0000;
        endcase
    end

endmodule

// File: doc/cp0_exc_ctrl.md
Name: cp0_exc_ctrl

Overview:
- Coprocessor-0 block that consumes the 5-bit exception code produced at the memory stage, merges it with external hardware interrupts and decides whether to take an exception.
- Holds SR, Cause, EPC and PRId; services mtc0/mfc0 and eret.
- Emits the flush/redirect request and the EPC to the pipeline controller and the NPC logic.

Parameters:
- PRID_VAL, 32'h0000_2021, read-only value of PRId (reg 15).
- HANDLER_PC, 32'h0000_4180, exception entry address driven on handler_pc.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all CP0 state immediately.
- pc  in  32  PC of the instruction currently in the M stage.
- bd_in  in  1  M-stage instruction sits in a branch delay slot.
- exc_code_in  in  5  [6:2] exception code from the M stage; 0 means no exception.
- hw_int  in  6  [7:2] external interrupt lines, level-sensitive.
- cp0_addr  in  5  register number for mtc0/mfc0.
- cp0_we  in  1  mtc0 write enable.
- cp0_wdata  in  32  mtc0 data.
- eret_in  in  1  eret in the M stage.
- cp0_rdata  out  32  mfc0 read data, combinational.
- req  out  1  take an exception/interrupt this cycle (flush all stages), combinational.
- epc_out  out  32  current EPC register, registered.
- handler_pc  out  32  constant HANDLER_PC.

Behaviour:
- Register fields:
  - SR(12): IM[15:10], EXL[1], IE[0]. All other bits read 0.
  - Cause(13): BD[31], IP[15:10], ExcCode[6:2]. All other bits read 0.
  - EPC(14): full 32 bits.
  - PRId(15): PRID_VAL.
  - Any other address reads 0, and writes to it are ignored.
- Reset (async): SR=0, Cause=0, EPC=0. Consequently epc_out=0, cp0_rdata=0 for addresses 12-14, and req=0.
- Cause.IP <= hw_int every cycle, regardless of EXL or writes. IP is read-only to mtc0.
- int_req = |(hw_int & SR.IM) & SR.IE & ~SR.EXL, evaluated on the live hw_int, not the latched IP.
- exc_req = (exc_code_in != 0) & ~SR.EXL.
- req = int_req | exc_req, combinational, same cycle. Zero latency from input to req.
- On the rising edge with req=1:
  - EXL<=1.
  - ExcCode <= int_req ? 0 : exc_code_in. Interrupt has priority over a synchronous exception.
  - BD <= bd_in.
  - EPC <= bd_in ? pc-4 : pc, with pc[1:0] kept as-is so a misaligned fetch records the faulting PC.
- Edge with req=0 and eret_in=1: EXL<=0. No other change.
- mtc0 with req=0:
  - addr 12 writes IM, EXL, IE.
  - addr 14 writes EPC.
  - addr 13 writes nothing (Cause is not software-writable).
  - addr 15 is ignored.
- Simultaneous events:
  - req=1 overrides any mtc0 and eret in the same cycle. The instruction is flushed, so its write is dropped.
  - mtc0 and eret in the same cycle cannot occur (one M-stage instruction). No defined priority beyond "req wins".
- Nesting: while EXL=1, req stays 0 even if exc_code_in≠0 or interrupts are pending. Pending interrupts fire on the first cycle after EXL clears.
- cp0_rdata reflects the register value before the current edge. There is no write-through bypass; the pipeline forwards.
- epc_out is the EPC register directly, not the incoming pc. A write to EPC at edge N is visible from cycle N+1.
- Reset asserted mid-handler clears EXL, so a later interrupt can be taken right after reset deasserts.

Decomposition:
- Shared package holds:
  - CP0 register numbers: SR=12, CAUSE=13, EPC=14, PRID=15.
  - ExcCode constants: INT=0, ADEL=4, ADES=5, RI=10, OV=12.
  - Field bit positions: IM 15:10, IP 15:10, EXL=1, IE=0, BD=31.
- The block is a single module with no sub-module. The register file is a few flops plus decode logic.

Test Plan:
- Reset with hw_int=6'h3f → req=0, epc_out=0, and cp0_rdata at addr 12, 13 and 14 reads 0.
- mtc0 addr12=32'h0000_0401 (IM[10], IE) with hw_int=6'b000001 → req=1 next cycle. On the edge: Cause.ExcCode=0, EXL=1, EPC=pc=32'h3008. The following cycle req=0.
- exc_code_in=5'd4, pc=32'h3010, bd_in=1, EXL=0 → req=1 the same cycle. After the edge: EPC=32'h300c, Cause=32'h8000_0010.
- Interrupt enabled and pending in the same cycle as exc_code_in=5'd12 → ExcCode recorded as 0 and EPC=pc.
- EXL=1 with exc_code_in=5'd10 → req=0 and no state change. Then eret_in=1 → EXL=0, and a pending enabled interrupt asserts req the next cycle.
- mtc0 addr14=32'h4000 in the same cycle as exc_code_in=5'd5, pc=32'h3020 → EPC=32'h3020 (the write is dropped). Then mtc0 addr13=32'hffff_ffff → Cause unchanged.
